// File: rtl/ImgRszPkg.sv
// Shared types for the resizer block scheduler: FSM states, pending-block entry, one-hot decode.
// No logic of its own; the entry index width bounds the block grid to 64x64.
package ImgRszPkg;

    localparam int RSZ_IMG_WIDTH_SIZE_DFLT  = 4;
    localparam int RSZ_IMG_HEIGHT_SIZE_DFLT = 4;
    localparam int BLK_IDX_W                = 6;
    localparam int ONEHOT_W                 = 1 << BLK_IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPT,
        ST_DRAIN,
        ST_DONE
    } sched_state_e;

    typedef struct packed {
        logic [BLK_IDX_W-1:0] blk_x;
        logic [BLK_IDX_W-1:0] blk_y;
    } blk_entry_t;

    function automatic logic [ONEHOT_W-1:0] onehot_dec(input logic [BLK_IDX_W-1:0] idx);
        logic [ONEHOT_W-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/img_rsz_blk_fifo.sv
// Synchronous FIFO, head readable from storage registers; a push shows up at the head next cycle.
// A push while full is taken only together with a pop; a pop while empty is ignored.
module img_rsz_blk_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             wr_en;
    logic             rd_en;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign wr_en   = push_i & (~full_o | pop_i);
    assign rd_en   = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/img_rsz_blk_sched.sv
// Tracks raster position of captured pixels, queues completed block indices and issues them to compute.
// Block visible 1 cycle after its last pixel; capture stalls only while the pending queue is full and not popping.
module img_rsz_blk_sched
    import ImgRszPkg::*;
#(
    parameter int RSZ_IMG_WIDTH_SIZE  = RSZ_IMG_WIDTH_SIZE_DFLT,
    parameter int RSZ_IMG_HEIGHT_SIZE = RSZ_IMG_HEIGHT_SIZE_DFLT,
    parameter int BLK_WIDTH_MAX_SZ_W  = 6,
    parameter int BLK_HEIGHT_MAX_SZ_W = 6,
    parameter int PEND_DEPTH          = 4
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic [BLK_WIDTH_MAX_SZ_W-1:0]  BlkSzHor,
    input  logic [BLK_HEIGHT_MAX_SZ_W-1:0] BlkSzVer,
    input  logic                           CompEngRdy,
    input  logic                           PxlCap,
    output logic                           PxlCapRdy,
    output logic                           IsFstPxl,
    output logic [RSZ_IMG_WIDTH_SIZE-1:0]  CompBlkXMsk,
    output logic [RSZ_IMG_HEIGHT_SIZE-1:0] CompBlkYMsk,
    output logic                           CompBlkVld,
    input  logic                           CompBlkRdy,
    output logic                           RszImgComp
);

    localparam int XW = (RSZ_IMG_WIDTH_SIZE > 1) ? $clog2(RSZ_IMG_WIDTH_SIZE) : 1;
    localparam int YW = (RSZ_IMG_HEIGHT_SIZE > 1) ? $clog2(RSZ_IMG_HEIGHT_SIZE) : 1;
    localparam int HW = BLK_WIDTH_MAX_SZ_W;
    localparam int VW = BLK_HEIGHT_MAX_SZ_W;

    localparam logic [XW-1:0] BLK_X_MAX = XW'(RSZ_IMG_WIDTH_SIZE - 1);
    localparam logic [YW-1:0] BLK_Y_MAX = YW'(RSZ_IMG_HEIGHT_SIZE - 1);

    sched_state_e   state_q, state_d;
    logic [HW-1:0]  pxl_x_q, pxl_x_d;
    logic [XW-1:0]  blk_x_q, blk_x_d;
    logic [VW-1:0]  pxl_y_q, pxl_y_d;
    logic [YW-1:0]  blk_y_q, blk_y_d;
    logic           any_acc_q, any_acc_d;

    logic           acc;
    logic           pop;
    logic           push;
    logic           last_pxl;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pxl_x_end;
    logic           pxl_y_end;
    logic           blk_x_end;
    logic           blk_y_end;
    blk_entry_t     push_ent;
    blk_entry_t     head_ent;

    assign pxl_x_end = (pxl_x_q == BlkSzHor - HW'(1));
    assign pxl_y_end = (pxl_y_q == BlkSzVer - VW'(1));
    assign blk_x_end = (blk_x_q == BLK_X_MAX);
    assign blk_y_end = (blk_y_q == BLK_Y_MAX);

    // Ready never depends on PxlCap, so capture sources may wait on it combinationally.
    assign pop       = ~fifo_empty & CompBlkRdy;
    assign PxlCapRdy = (state_q == ST_CAPT) & (~fifo_full | pop);
    assign acc       = PxlCap & PxlCapRdy;
    assign push      = acc & pxl_x_end & pxl_y_end;
    assign last_pxl  = push & blk_x_end & blk_y_end;

    always_comb begin
        push_ent       = '0;
        push_ent.blk_x = BLK_IDX_W'(blk_x_q);
        push_ent.blk_y = BLK_IDX_W'(blk_y_q);
    end

    img_rsz_blk_fifo #(
        .WIDTH ($bits(blk_entry_t)),
        .DEPTH (PEND_DEPTH)
    ) u_fifo (
        .clk     (Clk),
        .rst_n   (Reset),
        .push_i  (push),
        .din_i   (push_ent),
        .pop_i   (pop),
        .dout_o  (head_ent),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign CompBlkVld  = ~fifo_empty;
    assign CompBlkXMsk = fifo_empty ? '0 : RSZ_IMG_WIDTH_SIZE'(onehot_dec(head_ent.blk_x));
    assign CompBlkYMsk = fifo_empty ? '0 : RSZ_IMG_HEIGHT_SIZE'(onehot_dec(head_ent.blk_y));
    assign IsFstPxl    = (state_q == ST_CAPT) & ~any_acc_q &
                         (pxl_x_q == '0) & (blk_x_q == '0) & (pxl_y_q == '0) & (blk_y_q == '0);
    assign RszImgComp  = (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (CompEngRdy) state_d = ST_CAPT;
            ST_CAPT:  if (last_pxl)   state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
            ST_DONE:                  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Raster counters nest pixel-in-block X, block X, pixel-in-block Y, block Y.
    always_comb begin
        pxl_x_d   = pxl_x_q;
        blk_x_d   = blk_x_q;
        pxl_y_d   = pxl_y_q;
        blk_y_d   = blk_y_q;
        any_acc_d = any_acc_q;
        if (state_q == ST_IDLE) begin
            pxl_x_d   = '0;
            blk_x_d   = '0;
            pxl_y_d   = '0;
            blk_y_d   = '0;
            any_acc_d = 1'b0;
        end else if (acc) begin
            any_acc_d = 1'b1;
            if (!pxl_x_end) begin
                pxl_x_d = pxl_x_q + HW'(1);
            end else begin
                pxl_x_d = '0;
                if (!blk_x_end) begin
                    blk_x_d = blk_x_q + XW'(1);
                end else begin
                    blk_x_d = '0;
                    if (!pxl_y_end) begin
                        pxl_y_d = pxl_y_q + VW'(1);
                    end else begin
                        pxl_y_d = '0;
                        blk_y_d = blk_y_end ? '0 : blk_y_q + YW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            pxl_x_q   <= '0;
            blk_x_q   <= '0;
            pxl_y_q   <= '0;
            blk_y_q   <= '0;
            any_acc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pxl_x_q   <= pxl_x_d;
            blk_x_q   <= blk_x_d;
            pxl_y_q   <= pxl_y_d;
            blk_y_q   <= blk_y_d;
            any_acc_q <= any_acc_d;
        end
    end

endmodule

// File: tb/tb_img_rsz_blk_sched.sv
// Randomized bench for img_rsz_blk_sched on a 2x2 block grid with a 2-deep pending queue,
// scored against a raster-arithmetic model of pixel completion and queue occupancy.
module tb_img_rsz_blk_sched;

    localparam int GW    = 2;
    localparam int GH    = 2;
    localparam int DEPTH = 2;

    typedef struct {
        int x;
        int y;
    } blk_t;

    logic          Clk;
    logic          Reset;
    logic [5:0]    BlkSzHor;
    logic [5:0]    BlkSzVer;
    logic          CompEngRdy;
    logic          PxlCap;
    logic          PxlCapRdy;
    logic          IsFstPxl;
    logic [GW-1:0] CompBlkXMsk;
    logic [GH-1:0] CompBlkYMsk;
    logic          CompBlkVld;
    logic          CompBlkRdy;
    logic          RszImgComp;

    img_rsz_blk_sched #(
        .RSZ_IMG_WIDTH_SIZE  (GW),
        .RSZ_IMG_HEIGHT_SIZE (GH),
        .BLK_WIDTH_MAX_SZ_W  (6),
        .BLK_HEIGHT_MAX_SZ_W (6),
        .PEND_DEPTH          (DEPTH)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .BlkSzHor    (BlkSzHor),
        .BlkSzVer    (BlkSzVer),
        .CompEngRdy  (CompEngRdy),
        .PxlCap      (PxlCap),
        .PxlCapRdy   (PxlCapRdy),
        .IsFstPxl    (IsFstPxl),
        .CompBlkXMsk (CompBlkXMsk),
        .CompBlkYMsk (CompBlkYMsk),
        .CompBlkVld  (CompBlkVld),
        .CompBlkRdy  (CompBlkRdy),
        .RszImgComp  (RszImgComp)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_err = 0;

    // Model phase: 0 idle, 1 capturing, 2 draining, 3 completion cycle.
    int   m_ph = 0, m_pix = 0, m_hor = 1, m_ver = 1, m_imgs = 0;
    int   cyc = 0, last_hs_cyc = 0, occ = 0, rw = 0, col = 0, row = 0;
    int   n_acc = 0, fst_cnt = 0, comp_pulses = 0, prev_acc_idx = 0;
    bit   prev_acc = 0, exp_rdy = 0, acc = 0, pop = 0, last_b = 0;
    int   xm = 0, ym = 0;
    blk_t m_q[$];
    blk_t nb;
    int   obs_push[$];
    int   obs_hs[$];

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset) begin
            m_q.delete();
            m_ph     = 0;
            m_pix    = 0;
            prev_acc = 0;
        end else begin
            occ     = m_q.size();
            exp_rdy = (m_ph == 1) && ((occ < DEPTH) || (occ > 0 && CompBlkRdy));
            xm      = (occ > 0) ? (1 << m_q[0].x) : 0;
            ym      = (occ > 0) ? (1 << m_q[0].y) : 0;
            check_val("pxl_cap_rdy", int'(PxlCapRdy), int'(exp_rdy));
            check_val("comp_blk_vld", int'(CompBlkVld), int'(occ > 0));
            check_val("x_mask", int'(CompBlkXMsk), xm);
            check_val("y_mask", int'(CompBlkYMsk), ym);
            check_val("rsz_comp", int'(RszImgComp), int'(m_ph == 3));
            check_val("is_fst_pxl", int'(IsFstPxl), int'(m_ph == 1 && m_pix == 0));
            if (RszImgComp) begin
                comp_pulses++;
                check_val("comp_after_hs", cyc - last_hs_cyc, 2);
            end
            if (CompBlkVld && prev_acc) obs_push.push_back(prev_acc_idx);
            if (CompBlkVld && CompBlkRdy) begin
                obs_hs.push_back((int'(CompBlkXMsk) << 2) | int'(CompBlkYMsk));
                last_hs_cyc = cyc;
            end
            prev_acc = 0;
            last_b   = 0;
            acc      = PxlCap && exp_rdy;
            pop      = (occ > 0) && CompBlkRdy;
            if (acc) begin
                if (IsFstPxl) fst_cnt++;
                n_acc++;
                prev_acc     = 1;
                prev_acc_idx = m_pix;
                rw  = GW * m_hor;
                col = m_pix % rw;
                row = m_pix / rw;
                if ((col % m_hor == m_hor - 1) && (row % m_ver == m_ver - 1)) begin
                    nb.x = col / m_hor;
                    nb.y = row / m_ver;
                    m_q.push_back(nb);
                end
                last_b = (m_pix == rw * GH * m_ver - 1);
                m_pix++;
            end
            if (pop) void'(m_q.pop_front());
            case (m_ph)
                0: if (CompEngRdy) m_ph = 1;
                1: if (last_b) m_ph = 2;
                2: if (occ == 0) m_ph = 3;
                default: begin
                    m_ph  = 0;
                    m_pix = 0;
                    m_imgs++;
                end
            endcase
        end
        cyc++;
    end

    task automatic start_image(input int hor, input int ver);
        BlkSzHor    = 6'(hor);
        BlkSzVer    = 6'(ver);
        m_hor       = hor;
        m_ver       = ver;
        obs_push.delete();
        obs_hs.delete();
        fst_cnt     = 0;
        comp_pulses = 0;
        n_acc       = 0;
        @(posedge Clk); #1;
        CompEngRdy = 1'b1;
        @(posedge Clk); #1;
        CompEngRdy = 1'b0;
    endtask

    task automatic finish_image(input int start_imgs, input int rnd);
        int n;
        n = 0;
        while (m_imgs == start_imgs && n < 3000) begin
            PxlCap     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            CompBlkRdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge Clk); #1;
            n++;
        end
        PxlCap = 1'b0;
        check_val("img_timeout", int'(m_imgs != start_imgs), 1);
        check_val("comp_pulses", comp_pulses, 1);
        check_val("fst_pxl_cnt", fst_cnt, 1);
    endtask

    task automatic run_image(input int hor, input int ver, input int rnd);
        int s;
        s = m_imgs;
        start_image(hor, ver);
        finish_image(s, rnd);
    endtask

    task automatic check_pushes(input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        check_val("push_cnt", obs_push.size(), 4);
        for (int i = 0; i < 4; i++)
            check_val("push_idx", (i < obs_push.size()) ? obs_push[i] : -1, e[i]);
    endtask

    task automatic check_raster_hs();
        check_val("hs_cnt", obs_hs.size(), 4);
        for (int i = 0; i < 4; i++)
            check_val("hs_order", (i < obs_hs.size()) ? obs_hs[i] : -1,
                      ((1 << (i % GW)) << 2) | (1 << (i / GW)));
    endtask

    initial begin
        int s;
        int n;
        Reset      = 1'b0;
        BlkSzHor   = 6'd1;
        BlkSzVer   = 6'd1;
        CompEngRdy = 1'b0;
        PxlCap     = 1'b0;
        CompBlkRdy = 1'b0;
        #1;
        check_val("rst_pxl_cap_rdy", int'(PxlCapRdy), 0);
        check_val("rst_is_fst", int'(IsFstPxl), 0);
        check_val("rst_vld", int'(CompBlkVld), 0);
        check_val("rst_masks", int'({CompBlkXMsk, CompBlkYMsk}), 0);
        check_val("rst_comp", int'(RszImgComp), 0);
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;

        // Basic 2x2 blocks of 2x2 pixels, then an identical image back-to-back.
        run_image(2, 2, 0);
        check_pushes(5, 7, 13, 15);
        check_raster_hs();
        run_image(2, 2, 0);
        check_pushes(5, 7, 13, 15);

        // Non-square 3x1 blocks.
        run_image(3, 1, 0);
        check_pushes(2, 5, 8, 11);

        // Backpressure on 1x1 blocks, including push+pop while full.
        s = m_imgs;
        CompBlkRdy = 1'b0;
        start_image(1, 1);
        PxlCap = 1'b1;
        repeat (5) @(posedge Clk);
        #1;
        check_val("bp_acc_cnt", n_acc, 2);
        check_val("bp_rdy_low", int'(PxlCapRdy), 0);
        CompBlkRdy = 1'b1;
        #1;
        check_val("full_pushpop_rdy", int'(PxlCapRdy), 1);
        @(posedge Clk); #1;
        CompBlkRdy = 1'b0;
        #1;
        check_val("full_occ_kept", int'(PxlCapRdy), 0);
        check_val("full_acc_cnt", n_acc, 3);
        check_val("full_hs_cnt", obs_hs.size(), 1);
        finish_image(s, 0);
        check_raster_hs();

        // Reset after 9 of 12 pixels with a block pending.
        start_image(3, 1);
        PxlCap     = 1'b1;
        CompBlkRdy = 1'b1;
        n = 0;
        while (m_pix < 9 && n < 200) begin
            @(posedge Clk); #1;
            n++;
        end
        check_val("pre_rst_pix", m_pix, 9);
        check_val("pre_rst_vld", int'(CompBlkVld), 1);
        #1 Reset = 1'b0;
        #1;
        check_val("mid_rst_pxl_cap_rdy", int'(PxlCapRdy), 0);
        check_val("mid_rst_is_fst", int'(IsFstPxl), 0);
        check_val("mid_rst_vld", int'(CompBlkVld), 0);
        check_val("mid_rst_masks", int'({CompBlkXMsk, CompBlkYMsk}), 0);
        check_val("mid_rst_comp", int'(RszImgComp), 0);
        PxlCap = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;
        run_image(2, 2, 0);
        check_val("post_rst_first_blk", (obs_hs.size() > 0) ? obs_hs[0] : -1, 5);
        check_pushes(5, 7, 13, 15);

        // Randomized geometry, capture and ready patterns.
        for (int i = 0; i < 8; i++)
            run_image(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), 1);

        repeat (3) @(posedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
